pixel_packer: RTL

PIXEL_PACKER -- requirements
Module: pixel_packer

---
 rtl/pixel_packer_pkg.sv | 12 +
 rtl/pp_out_stage.sv | 38 +++
 rtl/pixel_packer.sv | 107 ++++++++++
 3 files changed

// File: rtl/pixel_packer_pkg.sv
// Shared state encoding and default geometry for the pixel packer.
package pixel_packer_pkg;

  localparam int DEFAULT_PIXEL_W = 24;
  localparam int DEFAULT_WORD_W  = 32;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

endpackage

// File: rtl/pp_out_stage.sv
// Output word register for the pixel packer: holds a word until the sink takes it.
module pp_out_stage
  import pixel_packer_pkg::*;
#(
  parameter int WORD_W = DEFAULT_WORD_W
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              load,
  input  logic [WORD_W-1:0] loadData,
  input  logic              loadLast,
  input  logic              wordReady,
  output logic [WORD_W-1:0] wordData,
  output logic              wordValid,
  output logic              wordLast,
  output logic              free
);

  // The register can take a new word when empty or when the sink drains it this cycle.
  assign free = !wordValid || wordReady;

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wordData  <= '0;
      wordValid <= 1'b0;
      wordLast  <= 1'b0;
    end else if (load) begin
      wordData  <= loadData;
      wordValid <= 1'b1;
      wordLast  <= loadLast;
    end else if (wordReady) begin
      wordValid <= 1'b0;
      wordLast  <= 1'b0;
    end
  end

endmodule

// File: rtl/pixel_packer.sv
// Packs MSB-first pixels into fixed-width words with flush padding and frame resync.
module pixel_packer
  import pixel_packer_pkg::*;
#(
  parameter int PIXEL_W = DEFAULT_PIXEL_W,
  parameter int WORD_W  = DEFAULT_WORD_W
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [PIXEL_W-1:0] i_pixelData,
  input  logic               i_pixelValid,
  output logic               o_pixelReady,
  input  logic               i_frameStart,
  input  logic               i_flush,
  output logic [WORD_W-1:0]  o_wordData,
  output logic               o_wordValid,
  input  logic               i_wordReady,
  output logic               o_wordLast,
  output logic               o_flushDone,
  output logic               o_overrun,
  output logic [7:0]         o_dropCount
);

  localparam int ACC_W     = WORD_W + PIXEL_W - 1;
  localparam int CNT_W     = $clog2(ACC_W + 1);
  localparam int PIX_SHIFT = ACC_W - PIXEL_W;
  localparam logic [CNT_W-1:0] WORD_CNT  = CNT_W'(WORD_W);
  localparam logic [CNT_W-1:0] PIXEL_CNT = CNT_W'(PIXEL_W);

  state_t            state, stateNext;
  logic [ACC_W-1:0]  acc, accNext, pixelAligned;
  logic [CNT_W-1:0]  cnt, cntAfterEmit, cntNext;
  logic              outFree, frameClear, fullAvail, partAvail, emit, emitLast, accept;

  assign pixelAligned = ACC_W'(i_pixelData) << PIX_SHIFT;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    fullAvail    = cnt >= WORD_CNT;
    partAvail    = (state == S_FLUSH) && (cnt != '0) && !fullAvail;
    frameClear   = (state == S_RUN) && i_frameStart;
    emit         = (fullAvail || partAvail) && outFree && !frameClear;

    cntAfterEmit = cnt;
    if (frameClear) begin
      cntAfterEmit = '0;
    end else if (emit) begin
      cntAfterEmit = fullAvail ? cnt - WORD_CNT : '0;
    end

    o_pixelReady = !i_reset && (state == S_RUN) && (cntAfterEmit < WORD_CNT);
    accept       = i_pixelValid && o_pixelReady;

    // Valid bits stay MSB-aligned with zeros below, so a padded word is just the top slice.
    accNext = frameClear ? '0 : (emit ? acc << WORD_W : acc);
    if (accept) begin
      accNext = accNext | (pixelAligned >> cntAfterEmit);
    end
    cntNext = accept ? cntAfterEmit + PIXEL_CNT : cntAfterEmit;

    emitLast    = emit && (state == S_FLUSH) && (cntAfterEmit == '0);
    o_flushDone = !i_reset && (state == S_FLUSH) && (cnt == '0);

    stateNext = state;
    case (state)
      S_RUN:   if (i_flush && !i_frameStart) stateNext = S_FLUSH;
      S_FLUSH: if (cnt == '0) stateNext = S_RUN;
      default: stateNext = S_RUN;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state       <= S_RUN;
      acc         <= '0;
      cnt         <= '0;
      o_overrun   <= 1'b0;
      o_dropCount <= '0;
    end else begin
      state <= stateNext;
      acc   <= accNext;
      cnt   <= cntNext;
      if (i_pixelValid && !o_pixelReady) begin
        o_overrun <= 1'b1;
      end
      if (frameClear && (cnt != '0) && (o_dropCount != 8'hFF)) begin
        o_dropCount <= o_dropCount + 8'd1;
      end
    end
  end

  pp_out_stage #(
    .WORD_W (WORD_W)
  ) u_outStage (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .load      (emit),
    .loadData  (acc[ACC_W-1 -: WORD_W]),
    .loadLast  (emitLast),
    .wordReady (i_wordReady),
    .wordData  (o_wordData),
    .wordValid (o_wordValid),
    .wordLast  (o_wordLast),
    .free      (outFree)
  );

endmodule
